// File: rtl/calc_pkg.sv
// Shared definitions for the decimal arithmetic sequencer: operation codes,
// sequencer state encoding, default scale limit and decimal helper functions.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int DP_MAX_DEF = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_ADDSUB = 3'd2,
        S_MUL    = 3'd3,
        S_DIV    = 3'd4,
        S_NORM   = 3'd5,
        S_DONE   = 3'd6
    } seq_state_e;

    // Helpers work on a 64-bit container so any magnitude up to 60 bits fits with headroom.
    function automatic logic [63:0] times10(input logic [63:0] x);
        return (x << 3) + (x << 1);
    endfunction

    function automatic logic [63:0] div10(input logic [63:0] x);
        return x / 64'd10;
    endfunction

    function automatic logic [3:0] mod10(input logic [63:0] x);
        return 4'(x % 64'd10);
    endfunction

endpackage

// File: rtl/calc_muldiv_core.sv
// Iterative datapath: right-shifting shift-add multiplier or restoring divider,
// one step per cycle; flags the final step so the sequencer can take the result.
module calc_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 last_o,
    output logic [2*WIDTH-1:0]   nxt_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q;
    logic               div_q;
    logic [CW-1:0]      count_q;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_sh_s;
    logic [WIDTH:0]     div_tr_s;

    // Accumulator holds {partial product, multiplier} or {remainder, quotient}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            count_q <= '0;
        end else if (load_i) begin
            acc_q   <= {{WIDTH{1'b0}}, a_i};
            opb_q   <= b_i;
            div_q   <= div_i;
            count_q <= '0;
        end else if (step_i) begin
            acc_q   <= acc_d;
            count_q <= count_q + CW'(1);
        end else begin
            acc_q   <= acc_q;
        end
    end

    // One multiply or divide iteration computed from the current accumulator.
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_sh_s  = acc_q[2*WIDTH-1:WIDTH-1];
        div_tr_s  = div_sh_s - {1'b0, opb_q};
        if (div_q) begin
            if (!div_tr_s[WIDTH]) begin
                acc_d = {div_tr_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
    end

    assign nxt_o  = acc_d;
    assign last_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/calc_seq_ctrl.sv
// Decimal arithmetic sequencer: scale alignment, add/sub/mul/div and normalisation.
// Define CALC_SEQ_TRIM_EN to also strip trailing fractional zeros from results.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DP_MAX = DP_MAX_DEF,
    parameter int DIV_DP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_mag,
    input  logic             a_neg,
    input  logic [2:0]       a_dp,
    input  logic [WIDTH-1:0] b_mag,
    input  logic             b_neg,
    input  logic [2:0]       b_dp,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_mag,
    output logic             res_neg,
    output logic [2:0]       res_dp,
    output logic             err_ovf,
    output logic             err_div0
);

`ifdef CALC_SEQ_TRIM_EN
    localparam logic TRIM_EN = 1'b1;
`else
    localparam logic TRIM_EN = 1'b0;
`endif

    seq_state_e         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic [3:0]         a_dp_q, a_dp_d, b_dp_q, b_dp_d;
    logic [WIDTH-1:0]   res_mag_q, res_mag_d;
    logic               res_neg_q, res_neg_d;
    logic [3:0]         res_dp_q, res_dp_d;
    logic               err_ovf_q, err_ovf_d, err_div0_q, err_div0_d;

    logic               core_load_s, core_step_s, core_last_s;
    logic [2*WIDTH-1:0] core_nxt_s;
    logic               scale_a_s, t10_ovf_s;
    logic [63:0]        t10_s;
    logic [WIDTH:0]     sum_s;
    logic               eff_b_neg_s;
    logic [WIDTH-1:0]   raw_mag_s, fin_mag_s, nd_mag_s;
    logic               raw_neg_s, raw_ovf_s, fin_neg_s, fin_ovf_s;
    logic [3:0]         raw_dp_s, fin_dp_s, nd_dp_s;
    seq_state_e         fin_state_s;

    // Dp fields are carried 4 bits wide internally: a product or a divide-aligned dividend can exceed 7.
    function automatic logic needs_norm(input logic [WIDTH-1:0] m, input logic [3:0] d);
        return (d > 4'(DP_MAX)) || (TRIM_EN && (d != 4'd0) && (mod10(64'(m)) == 4'd0));
    endfunction

    calc_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (core_load_s),
        .step_i (core_step_s),
        .div_i  (op_d == OP_DIV),
        .a_i    (a_d),
        .b_i    (b_d),
        .last_o (core_last_s),
        .nxt_o  (core_nxt_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            a_dp_q     <= 4'd0;
            b_dp_q     <= 4'd0;
            res_mag_q  <= '0;
            res_neg_q  <= 1'b0;
            res_dp_q   <= 4'd0;
            err_ovf_q  <= 1'b0;
            err_div0_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            a_dp_q     <= a_dp_d;
            b_dp_q     <= b_dp_d;
            res_mag_q  <= res_mag_d;
            res_neg_q  <= res_neg_d;
            res_dp_q   <= res_dp_d;
            err_ovf_q  <= err_ovf_d;
            err_div0_q <= err_div0_d;
        end
    end

    // Datapath helpers: alignment scaling, signed add/sub, normalisation step.
    always_comb begin
        if ((op_q == OP_DIV) || (a_dp_q < b_dp_q)) begin
            scale_a_s = 1'b1;
        end else begin
            scale_a_s = 1'b0;
        end
        t10_s       = times10(64'(scale_a_s ? a_q : b_q));
        t10_ovf_s   = |t10_s[63:WIDTH];
        sum_s       = {1'b0, a_q} + {1'b0, b_q};
        eff_b_neg_s = b_neg_q ^ (op_q == OP_SUB);
        nd_mag_s    = WIDTH'(div10(64'(res_mag_q)));
        nd_dp_s     = res_dp_q - 4'd1;
    end

    // Raw result of whichever execution unit is active.
    always_comb begin
        raw_mag_s = '0;
        raw_neg_s = 1'b0;
        raw_dp_s  = 4'd0;
        raw_ovf_s = 1'b0;
        case (state_q)
            S_ADDSUB: begin
                raw_dp_s = a_dp_q;
                if (a_neg_q == eff_b_neg_s) begin
                    raw_mag_s = sum_s[WIDTH-1:0];
                    raw_neg_s = a_neg_q;
                    raw_ovf_s = sum_s[WIDTH];
                end else if (a_q >= b_q) begin
                    raw_mag_s = a_q - b_q;
                    raw_neg_s = a_neg_q;
                end else begin
                    raw_mag_s = b_q - a_q;
                    raw_neg_s = eff_b_neg_s;
                end
            end
            S_MUL: begin
                raw_mag_s = core_nxt_s[WIDTH-1:0];
                raw_neg_s = a_neg_q ^ b_neg_q;
                raw_dp_s  = a_dp_q + b_dp_q;
                raw_ovf_s = |core_nxt_s[2*WIDTH-1:WIDTH];
            end
            S_DIV: begin
                raw_mag_s = core_nxt_s[WIDTH-1:0];
                raw_neg_s = a_neg_q ^ b_neg_q;
                raw_dp_s  = a_dp_q - b_dp_q;
            end
            default: begin
                raw_mag_s = '0;
            end
        endcase
    end

    // Final result of an execution step, and whether normalisation must follow.
    always_comb begin
        if (raw_ovf_s) begin
            fin_mag_s   = '0;
            fin_neg_s   = 1'b0;
            fin_dp_s    = 4'd0;
            fin_ovf_s   = 1'b1;
            fin_state_s = S_DONE;
        end else begin
            fin_mag_s   = raw_mag_s;
            fin_neg_s   = raw_neg_s & (raw_mag_s != '0);
            fin_dp_s    = raw_dp_s;
            fin_ovf_s   = 1'b0;
            fin_state_s = needs_norm(raw_mag_s, raw_dp_s) ? S_NORM : S_DONE;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        a_dp_d      = a_dp_q;
        b_dp_d      = b_dp_q;
        res_mag_d   = res_mag_q;
        res_neg_d   = res_neg_q;
        res_dp_d    = res_dp_q;
        err_ovf_d   = err_ovf_q;
        err_div0_d  = err_div0_q;
        core_load_s = 1'b0;
        core_step_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = op;
                    a_d        = a_mag;
                    b_d        = b_mag;
                    a_neg_d    = a_neg;
                    b_neg_d    = b_neg;
                    a_dp_d     = {1'b0, a_dp};
                    b_dp_d     = {1'b0, b_dp};
                    res_mag_d  = '0;
                    res_neg_d  = 1'b0;
                    res_dp_d   = 4'd0;
                    err_ovf_d  = 1'b0;
                    err_div0_d = 1'b0;
                    if ((op == OP_DIV) && (b_mag == '0)) begin
                        err_div0_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (op == OP_DIV) begin
                        if ({1'b0, a_dp} < ({1'b0, b_dp} + 4'(DIV_DP))) begin
                            state_d = S_ALIGN;
                        end else begin
                            state_d     = S_DIV;
                            core_load_s = 1'b1;
                        end
                    end else if (op == OP_MUL) begin
                        state_d     = S_MUL;
                        core_load_s = 1'b1;
                    end else if (a_dp != b_dp) begin
                        state_d = S_ALIGN;
                    end else begin
                        state_d = S_ADDSUB;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ALIGN: begin
                if (t10_ovf_s) begin
                    err_ovf_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    if (scale_a_s) begin
                        a_d    = t10_s[WIDTH-1:0];
                        a_dp_d = a_dp_q + 4'd1;
                    end else begin
                        b_d    = t10_s[WIDTH-1:0];
                        b_dp_d = b_dp_q + 4'd1;
                    end
                    if (op_q == OP_DIV) begin
                        if (a_dp_d >= (b_dp_q + 4'(DIV_DP))) begin
                            state_d     = S_DIV;
                            core_load_s = 1'b1;
                        end else begin
                            state_d = S_ALIGN;
                        end
                    end else if (a_dp_d == b_dp_d) begin
                        state_d = S_ADDSUB;
                    end else begin
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ADDSUB: begin
                state_d   = fin_state_s;
                res_mag_d = fin_mag_s;
                res_neg_d = fin_neg_s;
                res_dp_d  = fin_dp_s;
                err_ovf_d = fin_ovf_s;
            end
            S_MUL, S_DIV: begin
                core_step_s = 1'b1;
                if (core_last_s) begin
                    state_d   = fin_state_s;
                    res_mag_d = fin_mag_s;
                    res_neg_d = fin_neg_s;
                    res_dp_d  = fin_dp_s;
                    err_ovf_d = fin_ovf_s;
                end else begin
                    state_d = state_q;
                end
            end
            S_NORM: begin
                res_mag_d = nd_mag_s;
                res_dp_d  = nd_dp_s;
                res_neg_d = res_neg_q & (nd_mag_s != '0);
                if (needs_norm(nd_mag_s, nd_dp_s)) begin
                    state_d = S_NORM;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from registered state and result.
    always_comb begin
        ready    = (state_q == S_IDLE);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        res_mag  = res_mag_q;
        res_neg  = res_neg_q;
        res_dp   = res_dp_q[2:0];
        err_ovf  = err_ovf_q;
        err_div0 = err_div0_q;
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: directed and random requests against a
// decimal-arithmetic reference model; a separate monitor checks each done pulse.
module tb_calc_seq_ctrl;
    import calc_pkg::*;

`ifdef CALC_SEQ_TRIM_EN
    localparam bit TRIM = 1'b1;
`else
    localparam bit TRIM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a_mag, b_mag;
    logic        a_neg, b_neg;
    logic [2:0]  a_dp, b_dp;
    logic        ready, busy, done;
    logic [31:0] res_mag;
    logic        res_neg;
    logic [2:0]  res_dp;
    logic        err_ovf, err_div0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] am;
        logic        an;
        logic [2:0]  ad;
        logic [31:0] bm;
        logic        bn;
        logic [2:0]  bd;
    } req_t;

    typedef struct {
        logic [31:0] mag;
        logic        neg;
        logic [2:0]  dp;
        logic        ovf;
        logic        div0;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    calc_seq_ctrl #(.WIDTH(32), .DP_MAX(7), .DIV_DP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a_mag(a_mag), .a_neg(a_neg), .a_dp(a_dp),
        .b_mag(b_mag), .b_neg(b_neg), .b_dp(b_dp),
        .ready(ready), .busy(busy), .done(done),
        .res_mag(res_mag), .res_neg(res_neg), .res_dp(res_dp),
        .err_ovf(err_ovf), .err_div0(err_div0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: value = mag / 10^dp, evaluated with plain integer arithmetic.
    function automatic exp_t model(input req_t r);
        exp_t e;
        longint unsigned A, B, M;
        longint unsigned MAXV;
        longint sa, sb, s;
        int ad, bd, dp, lat;
        bit neg, err, div0, bneg;
        MAXV = 64'hFFFF_FFFF;
        A = r.am; B = r.bm; ad = r.ad; bd = r.bd;
        lat = 0; err = 0; div0 = 0; neg = 0; M = 0; dp = 0;
        case (r.op)
            OP_ADD, OP_SUB: begin
                bneg = r.bn ^ (r.op == OP_SUB);
                while (!err && ad != bd) begin
                    lat++;
                    if (ad < bd) begin A = A * 10; ad++; if (A > MAXV) err = 1; end
                    else begin B = B * 10; bd++; if (B > MAXV) err = 1; end
                end
                if (!err) begin
                    lat++;
                    sa = r.an ? -longint'(A) : longint'(A);
                    sb = bneg ? -longint'(B) : longint'(B);
                    s = sa + sb;
                    neg = (s < 0);
                    M = neg ? longint'(-s) : longint'(s);
                    if (M > MAXV) err = 1;
                    dp = ad;
                end
            end
            OP_MUL: begin
                lat = 32;
                M = A * B;
                if (M > MAXV) err = 1;
                dp = ad + bd;
                neg = r.an ^ r.bn;
            end
            default: begin
                if (B == 0) begin
                    div0 = 1;
                end else begin
                    while (!err && ad < bd + 2) begin
                        lat++; A = A * 10; ad++;
                        if (A > MAXV) err = 1;
                    end
                    if (!err) begin
                        lat += 32;
                        M = A / B;
                        dp = ad - bd;
                        neg = r.an ^ r.bn;
                    end
                end
            end
        endcase
        if (!err && !div0) begin
            while (dp > 7 || (TRIM && dp > 0 && (M % 10) == 0)) begin
                M = M / 10; dp--; lat++;
            end
        end
        if (err || div0) begin M = 0; neg = 0; dp = 0; end
        neg = neg && (M != 0);
        e.mag = M[31:0]; e.neg = neg; e.dp = dp[2:0];
        e.ovf = err; e.div0 = div0; e.lat = lat; e.cyc = 0;
        return e;
    endfunction

    task automatic garbage();
        start = ($urandom_range(0, 1) == 1);
        op    = 2'($urandom_range(0, 3));
        a_mag = $urandom; b_mag = $urandom;
        a_neg = ($urandom_range(0, 1) == 1); b_neg = ($urandom_range(0, 1) == 1);
        a_dp  = 3'($urandom_range(0, 7)); b_dp = 3'($urandom_range(0, 7));
    endtask

    // Called at a negedge; random start/input noise while busy must be ignored.
    task automatic issue(input req_t r);
        exp_t e;
        int guard = 0;
        while (ready !== 1'b1 && guard < 300) begin
            garbage();
            @(negedge clk);
            guard++;
        end
        if (ready !== 1'b1) begin
            check("ready_timeout", 0, 1);
        end else begin
            start = 1'b1; op = r.op;
            a_mag = r.am; a_neg = r.an; a_dp = r.ad;
            b_mag = r.bm; b_neg = r.bn; b_dp = r.bd;
            e = model(r);
            e.cyc = cyc + 1 + e.lat;
            sbq.push_back(e);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    function automatic logic [31:0] rnd_mag();
        int k;
        k = $urandom_range(0, 3);
        if (k == 0) return 32'($urandom_range(0, 20));
        else if (k == 3) return $urandom;
        else return 32'($urandom_range(0, 5000));
    endfunction

    // Monitor: pops the scoreboard on every done pulse and checks the held result afterwards.
    initial begin
        exp_t e;
        exp_t last_e;
        bit hold_chk;
        hold_chk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 0;
            end else begin
                if (hold_chk) begin
                    check("hold_mag", res_mag, last_e.mag);
                    check("hold_neg", res_neg, last_e.neg);
                    hold_chk = 0;
                end
                if (done) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("res_mag", res_mag, e.mag);
                        check("res_neg", res_neg, e.neg);
                        check("err_ovf", err_ovf, e.ovf);
                        check("err_div0", err_div0, e.div0);
                        if (!e.ovf && !e.div0) check("res_dp", res_dp, e.dp);
                        check("ready_on_done", ready, 0);
                        last_e = e;
                        hold_chk = 1;
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        req_t dir [14];
        req_t r;
        int guard;
        int dones;
        rst = 1'b1; start = 1'b0; op = 2'd0;
        a_mag = '0; b_mag = '0; a_neg = 1'b0; b_neg = 1'b0; a_dp = '0; b_dp = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res_mag", res_mag, 0);
        check("rst_res_neg", res_neg, 0);
        check("rst_res_dp", res_dp, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_err_div0", err_div0, 0);

        dir = '{
            '{OP_ADD, 32'd15,         1'b0, 3'd1, 32'd225, 1'b0, 3'd2},
            '{OP_SUB, 32'd3,          1'b0, 3'd0, 32'd5,   1'b0, 3'd0},
            '{OP_SUB, 32'd5,          1'b0, 3'd0, 32'd5,   1'b0, 3'd0},
            '{OP_MUL, 32'd125,        1'b0, 3'd2, 32'd4,   1'b0, 3'd1},
            '{OP_DIV, 32'd10,         1'b0, 3'd0, 32'd4,   1'b0, 3'd0},
            '{OP_DIV, 32'd7,          1'b0, 3'd0, 32'd0,   1'b0, 3'd0},
            '{OP_MUL, 32'hFFFF_FFFF,  1'b0, 3'd0, 32'd2,   1'b0, 3'd0},
            '{OP_ADD, 32'hFFFF_FFFF,  1'b0, 3'd0, 32'd1,   1'b0, 3'd0},
            '{OP_MUL, 32'd1,          1'b1, 3'd7, 32'd1,   1'b0, 3'd7},
            '{OP_ADD, 32'hFFFF_FFFF,  1'b0, 3'd0, 32'd1,   1'b0, 3'd3},
            '{OP_DIV, 32'h8000_0000,  1'b0, 3'd0, 32'd3,   1'b0, 3'd0},
            '{OP_DIV, 32'd7,          1'b0, 3'd5, 32'd2,   1'b0, 3'd0},
            '{OP_SUB, 32'd20,         1'b1, 3'd1, 32'd7,   1'b1, 3'd0},
            '{OP_DIV, 32'd100,        1'b0, 3'd7, 32'd3,   1'b0, 3'd7}
        };
        foreach (dir[i]) issue(dir[i]);

        for (int n = 0; n < 150; n++) begin
            r.op = 2'($urandom_range(0, 3));
            r.am = rnd_mag(); r.bm = rnd_mag();
            r.an = ($urandom_range(0, 1) == 1); r.bn = ($urandom_range(0, 1) == 1);
            r.ad = 3'($urandom_range(0, 7)); r.bd = 3'($urandom_range(0, 7));
            if (!busy && $urandom_range(0, 3) == 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            issue(r);
        end

        guard = 0;
        while ((sbq.size() != 0 || ready !== 1'b1) && guard < 300) begin
            garbage();
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check("drain_timeout", sbq.size(), 0);
        @(negedge clk);

        // Reset mid-multiply: outputs return to reset values at once and no done follows.
        start = 1'b1; op = OP_MUL; a_mag = 32'd1234; b_mag = 32'd56;
        a_neg = 1'b0; b_neg = 1'b0; a_dp = 3'd0; b_dp = 3'd0;
        @(negedge clk);
        start = 1'b0;
        check("mul_busy", busy, 1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_ready", ready, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_res_mag", res_mag, 0);
        check("arst_err_ovf", err_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_rst", dones, 0);
        check("idle_after_rst", ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
